key_input_fsm: RTL and testbench
================================

KEY_INPUT_FSM -- requirements
Module: key_input_fsm

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the number of consecutive stable clk cycles (10 ms at 50 MHz) needed to accept a key level.
REQ-002 The block SHALL have parameter CNT_W, default 20, giving the debounce counter width; DEBOUNCE_CYCLES SHALL be less than 2^CNT_W.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sel_keys_raw  input  4  raw asynchronous selector-move buttons, active-high.
REQ-006 dir_keys_raw  input  4  raw asynchronous piece-move buttons (up, down, left, right), active-high.
REQ-007 consume  input  1  one-cycle pulse from game_controller_fsm when it leaves WAIT_PLAYER and accepts the held command.
REQ-008 selector  output  4  one-hot selector command, held until consumed; feeds game_controller_fsm selector.
REQ-009 direction  output  4  one-hot direction command, held until consumed; feeds game_controller_fsm direction.
REQ-010 valid  output  1  high while a command is held on selector/direction.
REQ-011 dropped  output  1  sticky flag; set when a press event is discarded while a command is held.

Function
REQ-012 The block SHALL pass all 8 raw bits {dir_keys_raw, sel_keys_raw} through a 2-flop synchronizer before any other use.
REQ-013 The block SHALL keep an 8-bit candidate vector and a shared CNT_W-bit stable counter.
- If the synchronized vector differs from the candidate, the candidate loads the synchronized vector and the counter clears to 0.
- Otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
REQ-014 The debounced vector SHALL load the candidate in the cycle the counter reaches DEBOUNCE_CYCLES; a bounce shorter than DEBOUNCE_CYCLES cycles SHALL never reach the debounced vector.
REQ-015 A press event SHALL be a 0->1 transition of any debounced bit, found by comparing against a one-cycle-delayed copy of the debounced vector.
REQ-016 Priority when several events share a cycle: sel bit 0 (highest) through sel bit 3, then dir bit 0 through dir bit 3 (lowest); only the winner is captured.
REQ-017 The state machine SHALL have 3 states: IDLE, HOLD, WAIT_RELEASE.
- IDLE: on any press event, capture the winner into selector or direction (the other output stays 0000), set valid=1, go to HOLD. consume is ignored.
- HOLD: outputs frozen and new events ignored. Any event that arrives here sets dropped=1. On consume, clear selector, direction and valid on the next edge and go to WAIT_RELEASE.
- WAIT_RELEASE: stay until all 8 debounced bits are 0, then go to IDLE. Events here are ignored and do not set dropped.
REQ-018 Simultaneous consume and press event in HOLD: consume wins, the event is discarded and dropped is set.
REQ-019 A consume pulse lasting more than one cycle SHALL have the same effect as a single pulse.
REQ-020 In every cycle, at most one bit across selector and direction SHALL be 1, and valid SHALL equal the OR of those 8 bits.
REQ-021 dropped SHALL clear on the same edge that consume clears valid.
REQ-022 Latency: a raw bit that rises to 1 (all others 0, block in IDLE) and stays stable SHALL produce valid=1 exactly DEBOUNCE_CYCLES+4 clk edges after the first edge that samples it high.
REQ-023 Release of a key SHALL never generate a command.

Reset
REQ-024 While reset is high, the following SHALL be 0: synchronizer flops, candidate, counter, debounced vector, delayed copy, selector, direction, valid, dropped. The state SHALL be IDLE.
REQ-025 Reset asserted mid-operation SHALL abort any held command at once.
REQ-026 A key still held when reset deasserts SHALL produce a new press event after debounce, because the debounced vector restarts at 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 sel_keys_raw=0001 held steady -> selector=0001, direction=0000, valid=1 exactly 8 edges after first sample; outputs stay held until consume.
REQ-028 dir_keys_raw bit 2 toggling every 2 cycles for 20 cycles, then 0 -> valid never asserts.
REQ-029 sel_keys_raw=1000 and dir_keys_raw=0001 rising in the same cycle -> selector=1000, direction=0000; after consume, no second command until both keys are released and dir bit 0 is pressed again.
REQ-030 Command held, then dir_keys_raw=0010 pressed -> outputs unchanged and dropped=1; consume pulse -> valid=0 and dropped=0 on the next edge.
REQ-031 Reset pulse while valid=1 with sel_keys_raw=0100 still held -> all outputs 0 immediately; after reset deasserts, selector=0100 and valid=1 after 8 edges.

Source files
------------

// File: rtl/key_input_fsm.sv
// Debounced key front end for the game controller: synchronizes and debounces the
// selector/direction buttons, and holds one one-hot command until the controller consumes it.
module key_input_fsm #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sel_keys_raw,
  input  logic [3:0] dir_keys_raw,
  input  logic       consume,
  output logic [3:0] selector,
  output logic [3:0] direction,
  output logic       valid,
  output logic       dropped,
  output logic [1:0] o_state_dbg
);

  // Handshake: a command is offered while valid=1 and stays frozen until a
  // cycle with consume=1 is seen in HOLD; extra consume cycles are ignored.

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD         = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(DEBOUNCE_CYCLES);

  state_t           r_state;
  logic [7:0]       r_sync1;
  logic [7:0]       r_sync2;
  logic [7:0]       r_cand;
  logic [7:0]       r_deb;
  logic [7:0]       r_deb_d;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [7:0]       w_press;
  logic [7:0]       w_win;

  assign w_cnt_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_press   = r_deb & ~r_deb_d;
  // Isolate the lowest set bit: sel[0] has the highest priority, dir[3] the lowest.
  assign w_win     = w_press & (~w_press + 8'd1);

  assign o_state_dbg = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
    end else begin
      r_sync1 <= {dir_keys_raw, sel_keys_raw};
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc == C_MAX) begin
          r_deb <= r_cand;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      selector  <= '0;
      direction <= '0;
      valid     <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_press) begin
            selector  <= w_win[3:0];
            direction <= w_win[7:4];
            valid     <= 1'b1;
            r_state   <= HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            selector  <= '0;
            direction <= '0;
            valid     <= 1'b0;
            // A press colliding with consume is lost, so it is the one case
            // where dropped survives the consume edge.
            dropped   <= |w_press;
            r_state   <= WAIT_RELEASE;
          end else if (|w_press) begin
            dropped <= 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (r_deb == 8'd0) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_input_fsm.sv
// Bench for key_input_fsm with a short debounce window: directed vector table,
// hand-written reset/bounce sequences and a random run against a sample-history model.
module tb_key_input_fsm;
  localparam int D  = 4;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sel_raw = '0;
  logic [3:0] dir_raw = '0;
  logic       consume = 1'b0;
  logic [3:0] selector;
  logic [3:0] direction;
  logic       valid;
  logic       dropped;
  logic [1:0] state_dbg;

  key_input_fsm #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sel_keys_raw (sel_raw),
    .dir_keys_raw (dir_raw),
    .consume      (consume),
    .selector     (selector),
    .direction    (direction),
    .valid        (valid),
    .dropped      (dropped),
    .o_state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: commands the model captured, waiting for the DUT's valid to rise
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;

  // reference model: raw samples per edge (index 0 newest), debounced level and its delay
  logic [7:0] m_hist [0:D+2];
  logic [7:0] m_deb, m_deb_d, m_cmd;
  logic       m_dropped;
  int         m_phase;   // 0 waiting for press, 1 command held, 2 waiting for all keys up

  typedef struct {
    logic [3:0] sel;
    logic [3:0] dir;
    logic       cons;
    int         cycles;
    logic [3:0] e_sel;
    logic [3:0] e_dir;
    logic       e_valid;
    logic       e_dropped;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lowest_bit(input logic [7:0] v);
    logic [7:0] r;
    logic       found;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        r[i] = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= D + 2; i++) m_hist[i] = '0;
    m_deb = '0;
    m_deb_d = '0;
    m_cmd = '0;
    m_dropped = 1'b0;
    m_phase = 0;
    exp_q.delete();
  endtask

  // one clock edge: a key level is accepted once D+1 consecutive synchronized
  // samples agree; synchronization delays each raw sample by two edges
  task automatic model_step();
    logic [7:0] press;
    logic       stable;
    press = m_deb & ~m_deb_d;
    case (m_phase)
      0: if (press != 0) begin
           m_cmd = lowest_bit(press);
           m_phase = 1;
           exp_q.push_back(m_cmd);
         end
      1: if (consume) begin
           m_cmd = '0;
           m_dropped = (press != 0);
           m_phase = 2;
         end else if (press != 0) begin
           m_dropped = 1'b1;
         end
      default: if (m_deb == 0) m_phase = 0;
    endcase
    m_deb_d = m_deb;
    for (int i = D + 2; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = {dir_raw, sel_raw};
    stable = 1'b1;
    for (int i = 3; i <= D + 2; i++) if (m_hist[i] != m_hist[2]) stable = 1'b0;
    if (stable) m_deb = m_hist[2];
  endtask

  task automatic model_check();
    chk("model_sel", {4'd0, selector}, {4'd0, m_cmd[3:0]});
    chk("model_dir", {4'd0, direction}, {4'd0, m_cmd[7:4]});
    chk("model_valid", {7'd0, valid}, {7'd0, |m_cmd});
    chk("model_dropped", {7'd0, dropped}, {7'd0, m_dropped});
    chk("onehot", 8'($countones({direction, selector}) <= 1), 8'd1);
  endtask

  task automatic sb_check();
    if (valid && !prev_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%h required=none t=%0t", {direction, selector}, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks--;
        chk("sb_cmd", {direction, selector}, e);
      end
    end
    prev_valid = valid;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
    sb_check();
  endtask

  // called at a negedge; reset must clear the outputs without waiting for an edge
  task automatic do_reset(input int cyc);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_sel", {4'd0, selector}, 8'd0);
    chk("rst_dir", {4'd0, direction}, 8'd0);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_dropped", {7'd0, dropped}, 8'd0);
    chk("rst_state", {6'd0, state_dbg}, 8'd0);
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    prev_valid = 1'b0;
  endtask

  task automatic add(input logic [3:0] s, input logic [3:0] d, input logic c, input int n,
                     input logic [3:0] es, input logic [3:0] ed, input logic ev, input logic edr);
    vec_t v;
    v.sel = s; v.dir = d; v.cons = c; v.cycles = n;
    v.e_sel = es; v.e_dir = ed; v.e_valid = ev; v.e_dropped = edr;
    vecs.push_back(v);
  endtask

  initial begin
    // single press: silent for 7 edges, command on the 8th, then held
    add(4'b0001, 4'b0000, 0, 7, 4'b0000, 4'b0000, 0, 0);
    add(4'b0001, 4'b0000, 0, 1, 4'b0001, 4'b0000, 1, 0);
    add(4'b0001, 4'b0000, 0, 5, 4'b0001, 4'b0000, 1, 0);
    // second key while held: outputs frozen, dropped set; consume clears both
    add(4'b0001, 4'b0010, 0, 8, 4'b0001, 4'b0000, 1, 1);
    add(4'b0001, 4'b0010, 1, 1, 4'b0000, 4'b0000, 0, 0);
    add(4'b0001, 4'b0010, 1, 3, 4'b0000, 4'b0000, 0, 0);
    add(4'b0000, 4'b0000, 0, 8, 4'b0000, 4'b0000, 0, 0);

    model_reset();
    @(negedge clk);
    do_reset(2);

    for (int i = 0; i < vecs.size(); i++) begin
      sel_raw = vecs[i].sel;
      dir_raw = vecs[i].dir;
      consume = vecs[i].cons;
      repeat (vecs[i].cycles) tick();
      chk($sformatf("vec%0d_sel", i), {4'd0, selector}, {4'd0, vecs[i].e_sel});
      chk($sformatf("vec%0d_dir", i), {4'd0, direction}, {4'd0, vecs[i].e_dir});
      chk($sformatf("vec%0d_valid", i), {7'd0, valid}, {7'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_dropped", i), {7'd0, dropped}, {7'd0, vecs[i].e_dropped});
    end

    // bounce on dir[2], two cycles per level, never long enough to be accepted
    for (int i = 0; i < 10; i++) begin
      dir_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      repeat (2) begin
        tick();
        chk("bounce_valid", {7'd0, valid}, 8'd0);
      end
    end
    dir_raw = '0;
    repeat (10) tick();
    chk("bounce_after", {7'd0, valid}, 8'd0);

    // simultaneous sel[3] and dir[0]: selector wins; no second command until all up
    sel_raw = 4'b1000; dir_raw = 4'b0001;
    repeat (8) tick();
    chk("prio_sel", {4'd0, selector}, 8'h08);
    chk("prio_dir", {4'd0, direction}, 8'h00);
    chk("prio_dropped", {7'd0, dropped}, 8'd0);
    consume = 1'b1; tick(); consume = 1'b0;
    chk("prio_consumed", {7'd0, valid}, 8'd0);
    sel_raw = 4'b0000;
    repeat (10) tick();
    chk("prio_dir_still_held", {7'd0, valid}, 8'd0);
    dir_raw = 4'b0000;
    repeat (10) tick();
    chk("prio_released", {7'd0, valid}, 8'd0);
    dir_raw = 4'b0001;
    repeat (8) tick();
    chk("prio_repress_dir", {4'd0, direction}, 8'h01);
    chk("prio_repress_valid", {7'd0, valid}, 8'd1);
    consume = 1'b1; tick(); consume = 1'b0;
    dir_raw = 4'b0000;
    repeat (10) tick();

    // reset while a command is held and the key stays down
    sel_raw = 4'b0100;
    repeat (8) tick();
    chk("rsthold_valid", {7'd0, valid}, 8'd1);
    do_reset(2);
    repeat (7) tick();
    chk("rsthold_early", {7'd0, valid}, 8'd0);
    tick();
    chk("rsthold_sel", {4'd0, selector}, 8'h04);
    chk("rsthold_valid2", {7'd0, valid}, 8'd1);
    consume = 1'b1; tick(); consume = 1'b0;
    sel_raw = 4'b0000;
    repeat (10) tick();

    // random segments of held key patterns, consume pulses and occasional resets
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        if ($urandom_range(0, 1) == 1)
          {dir_raw, sel_raw} = 8'd0;
        else
          {dir_raw, sel_raw} = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
        consume = ($urandom_range(0, 3) == 0);
        repeat ($urandom_range(1, 12)) tick();
      end
    end

    {dir_raw, sel_raw} = 8'd0;
    consume = 1'b1;
    repeat (3) tick();
    consume = 1'b0;
    repeat (10) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
